// File: rtl/apb_alarm_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_alarm_master
// Brief    : APB initiator for the alarm peripheral plus a periodic time-now
//            poller. Define APB_MASTER_TIMEOUT_EN to add the ACCESS timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_alarm_master #(
  parameter int unsigned POLL_PERIOD    = 1000,
  parameter logic [31:0] POLL_ADDR      = 32'h8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        pclk_i,
  input  logic        presetn_i,
  // request / response side
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_strb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  // poller
  input  logic        poll_en_i,
  output logic [15:0] time_now_o,
  output logic        time_now_valid_o,
  output logic        poll_err_o,
  // APB
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic        pready_i,
  input  logic [31:0] prdata_i,
  input  logic        pslverr_i
);

  localparam int unsigned CNT_W = $clog2(POLL_PERIOD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             tag_poll;
  logic             poll_pending;
  logic [CNT_W-1:0] poll_cnt;
  logic             poll_tc;
  logic             accept_ext;
  logic             issue_poll;
  logic             complete;
  logic             abort;
  logic             timeout_hit;

  assign poll_tc = poll_en_i && (poll_cnt == CNT_W'(POLL_PERIOD - 1));

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] access_cnt;

  // Counts completed ACCESS cycles of the current transfer; zero on entry.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      access_cnt <= '0;
    end else if (state != ACCESS) begin
      access_cnt <= '0;
    end else if (!timeout_hit) begin
      access_cnt <= access_cnt + TO_W'(1);
    end
  end

  assign timeout_hit = (access_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // No counter: never true for a legal TIMEOUT_CYCLES, so ACCESS waits for pready_i.
  assign timeout_hit = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    accept_ext  = 1'b0;
    issue_poll  = 1'b0;
    complete    = 1'b0;
    abort       = 1'b0;
    req_ready_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = !poll_pending;
        if (req_valid_i && !poll_pending) begin
          accept_ext = 1'b1;
          state_nxt  = SETUP;
        end else if (poll_pending) begin
          issue_poll = 1'b1;
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        psel_o    = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        // pready_i in the last allowed cycle still completes normally
        if (pready_i) begin
          complete  = 1'b1;
          state_nxt = tag_poll ? IDLE : RESP;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = tag_poll ? IDLE : RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      tag_poll         <= 1'b0;
      paddr_o          <= '0;
      pwrite_o         <= 1'b0;
      pwdata_o         <= '0;
      pstrb_o          <= '0;
      rsp_rdata_o      <= '0;
      rsp_err_o        <= 1'b0;
      time_now_o       <= '0;
      time_now_valid_o <= 1'b0;
      poll_err_o       <= 1'b0;
    end else begin
      time_now_valid_o <= 1'b0;
      poll_err_o       <= 1'b0;
      if (accept_ext) begin
        tag_poll <= 1'b0;
        paddr_o  <= req_addr_i;
        pwrite_o <= req_write_i;
        pwdata_o <= req_wdata_i;
        pstrb_o  <= req_strb_i;
      end else if (issue_poll) begin
        tag_poll <= 1'b1;
        paddr_o  <= POLL_ADDR;
        pwrite_o <= 1'b0;
        pstrb_o  <= '0;
      end
      if (complete || abort) begin
        if (tag_poll) begin
          if (complete && !pslverr_i) begin
            time_now_o       <= prdata_i[15:0];
            time_now_valid_o <= 1'b1;
          end else begin
            poll_err_o <= 1'b1;
          end
        end else begin
          rsp_rdata_o <= (abort || pwrite_o) ? '0 : prdata_i;
          rsp_err_o   <= abort || pslverr_i;
        end
      end
    end
  end

  // A terminal count while a poll is already pending is dropped, not queued.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      poll_cnt     <= '0;
      poll_pending <= 1'b0;
    end else if (!poll_en_i) begin
      poll_cnt     <= '0;
      poll_pending <= 1'b0;
    end else begin
      poll_cnt <= poll_tc ? '0 : poll_cnt + CNT_W'(1);
      if (issue_poll) begin
        poll_pending <= 1'b0;
      end else if (poll_tc) begin
        poll_pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
